// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised UART receiver with parity, framing and break handling
module uart_rx_param #(
    parameter int BASE_FREQ = 50_000_000,
    parameter int BAUDRATE  = 115_200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] parallel_out,
    output logic                 data_valid,
    output logic                 parity_error,
    output logic                 framing_error,
    output logic                 busy
);
    localparam int          CPB     = BASE_FREQ / BAUDRATE;
    localparam logic [31:0] HALF_M1 = 32'(CPB / 2 - 1);
    localparam logic [31:0] FULL_M1 = 32'(CPB - 1);
    localparam logic        PAR_EN  = (PARITY == 1) || (PARITY == 2);
    localparam logic        PAR_ODD = (PARITY == 2);
    localparam int          NSTOP   = (STOP_BITS == 2) ? 2 : 1;
    localparam logic [3:0]  D_LAST  = 4'(DATA_BITS - 1);
    localparam logic [1:0]  S_LAST  = 2'(NSTOP - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    logic [2:0]           state;
    logic [31:0]          clock_ctr;
    logic [3:0]           d_idx;
    logic [1:0]           s_idx;
    logic                 sync_1;
    logic                 rx_s;
    logic                 armed;
    logic                 par_err;
    logic                 frame_err;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 par_calc;
    logic                 frame_now;

    assign busy      = (state != ST_IDLE);
    assign par_calc  = (^shift_reg) ^ rx_s;
    assign frame_now = frame_err | ~rx_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1 <= 1'b1;
            rx_s   <= 1'b1;
        end else begin
            sync_1 <= serial_in;
            rx_s   <= sync_1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            clock_ctr     <= '0;
            d_idx         <= '0;
            s_idx         <= '0;
            armed         <= 1'b1;
            par_err       <= 1'b0;
            frame_err     <= 1'b0;
            shift_reg     <= '0;
            parallel_out  <= '0;
            data_valid    <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rx_s) begin
                        armed <= 1'b1;
                    end
                    if (armed && !rx_s) begin
                        state     <= ST_START;
                        clock_ctr <= '0;
                        par_err   <= 1'b0;
                        frame_err <= 1'b0;
                    end
                end
                ST_START: begin
                    if (clock_ctr == HALF_M1) begin
                        clock_ctr <= '0;
                        d_idx     <= '0;
                        s_idx     <= '0;
                        // a high line at mid start bit is a glitch, not a frame
                        state     <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        clock_ctr <= clock_ctr + 32'd1;
                    end
                end
                ST_DATA: begin
                    if (clock_ctr == FULL_M1) begin
                        clock_ctr <= '0;
                        shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                        d_idx     <= d_idx + 4'd1;
                        if (d_idx == D_LAST) begin
                            state <= PAR_EN ? ST_PARITY : ST_STOP;
                        end
                    end else begin
                        clock_ctr <= clock_ctr + 32'd1;
                    end
                end
                ST_PARITY: begin
                    if (clock_ctr == FULL_M1) begin
                        clock_ctr <= '0;
                        par_err   <= PAR_ODD ? ~par_calc : par_calc;
                        state     <= ST_STOP;
                    end else begin
                        clock_ctr <= clock_ctr + 32'd1;
                    end
                end
                ST_STOP: begin
                    if (clock_ctr == FULL_M1) begin
                        clock_ctr <= '0;
                        frame_err <= frame_now;
                        s_idx     <= s_idx + 2'd1;
                        if (s_idx == S_LAST) begin
                            parallel_out  <= shift_reg;
                            data_valid    <= 1'b1;
                            parity_error  <= par_err;
                            framing_error <= frame_now;
                            // a low stop bit may be a break: wait for idle-high before rearming
                            armed         <= ~frame_now;
                            state         <= ST_IDLE;
                        end
                    end else begin
                        clock_ctr <= clock_ctr + 32'd1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    clock_ctr <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - directed self-checking bench for uart_rx_param
module tb_uart_rx_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic line_a = 1'b1, line_b = 1'b1, line_c = 1'b1;

    logic [7:0] po_a, po_b;
    logic [6:0] po_c;
    logic dv_a, pe_a, fe_a, busy_a;
    logic dv_b, pe_b, fe_b, busy_b;
    logic dv_c, pe_c, fe_c, busy_c;

    int n_checks = 0;
    int n_pass   = 0;
    int cnt_a = 0, cnt_b = 0, cnt_c = 0;
    int dbl = 0;
    logic prev_a = 1'b0, prev_b = 1'b0, prev_c = 1'b0;
    logic busy_ok;

    always #5 clk = ~clk;

    uart_rx_param #(.BASE_FREQ(1_600_000), .BAUDRATE(100_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
        .clk(clk), .rst(rst), .serial_in(line_a), .parallel_out(po_a), .data_valid(dv_a),
        .parity_error(pe_a), .framing_error(fe_a), .busy(busy_a));

    uart_rx_param #(.BASE_FREQ(1_600_000), .BAUDRATE(100_000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_b (
        .clk(clk), .rst(rst), .serial_in(line_b), .parallel_out(po_b), .data_valid(dv_b),
        .parity_error(pe_b), .framing_error(fe_b), .busy(busy_b));

    uart_rx_param #(.BASE_FREQ(1_600_000), .BAUDRATE(100_000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_c (
        .clk(clk), .rst(rst), .serial_in(line_c), .parallel_out(po_c), .data_valid(dv_c),
        .parity_error(pe_c), .framing_error(fe_c), .busy(busy_c));

    always @(negedge clk) begin
        if (dv_a) begin cnt_a++; if (prev_a) dbl++; end
        if (dv_b) begin cnt_b++; if (prev_b) dbl++; end
        if (dv_c) begin cnt_c++; if (prev_c) dbl++; end
        prev_a = dv_a;
        prev_b = dv_b;
        prev_c = dv_c;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic drive(input int which, input logic v);
        case (which)
            0:       line_a = v;
            1:       line_b = v;
            default: line_c = v;
        endcase
    endtask

    function automatic logic busy_of(input int which);
        case (which)
            0:       return busy_a;
            1:       return busy_b;
            default: return busy_c;
        endcase
    endfunction

    function automatic logic [15:0] frame(input logic [8:0] d, input int db, input int par,
                                          input logic pbit, input int ns, input logic s2);
        logic [15:0] v;
        int idx;
        v = 16'hFFFF;
        v[0] = 1'b0;
        for (int i = 0; i < db; i++) v[1+i] = d[i];
        idx = 1 + db;
        if (par != 0) begin v[idx] = pbit; idx++; end
        v[idx] = 1'b1;
        if (ns == 2) v[idx+1] = s2;
        return v;
    endfunction

    // each bit lasts 16 cycles; busy is sampled near every bit centre
    task automatic send_bits(input int which, input logic [15:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            drive(which, v[i]);
            repeat (8) @(negedge clk);
            busy_ok = busy_ok & busy_of(which);
            repeat (8) @(negedge clk);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_po", 32'(po_a), 32'h0);
        check("rst_dv", 32'(dv_a), 32'h0);
        check("rst_pe", 32'(pe_a), 32'h0);
        check("rst_fe", 32'(fe_a), 32'h0);
        check("rst_busy", 32'(busy_a), 32'h0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        busy_ok = 1'b1;
        send_bits(0, frame(9'h0A5, 8, 0, 1'b0, 1, 1'b1), 10);
        repeat (4) @(negedge clk);
        check("t1_cnt", 32'(cnt_a), 32'd1);
        check("t1_po", 32'(po_a), 32'hA5);
        check("t1_pe", 32'(pe_a), 32'h0);
        check("t1_fe", 32'(fe_a), 32'h0);
        check("t1_busy_frame", 32'(busy_ok), 32'h1);
        check("t1_busy_after", 32'(busy_a), 32'h0);

        send_bits(1, frame(9'h007, 8, 1, 1'b1, 1, 1'b1), 11);
        repeat (4) @(negedge clk);
        check("t2_cnt1", 32'(cnt_b), 32'd1);
        check("t2_pe_ok", 32'(pe_b), 32'h0);
        check("t2_po1", 32'(po_b), 32'h07);
        send_bits(1, frame(9'h007, 8, 1, 1'b0, 1, 1'b1), 11);
        repeat (4) @(negedge clk);
        check("t2_cnt2", 32'(cnt_b), 32'd2);
        check("t2_pe_bad", 32'(pe_b), 32'h1);
        check("t2_po2", 32'(po_b), 32'h07);
        check("t2_fe", 32'(fe_b), 32'h0);

        send_bits(2, frame(9'h055, 7, 1, 1'b1, 2, 1'b0), 11);
        repeat (4) @(negedge clk);
        check("t3_cnt1", 32'(cnt_c), 32'd1);
        check("t3_fe", 32'(fe_c), 32'h1);
        check("t3_pe", 32'(pe_c), 32'h0);
        check("t3_po", 32'(po_c), 32'h55);
        repeat (640) @(negedge clk);
        check("t3_break_cnt", 32'(cnt_c), 32'd1);
        check("t3_break_busy", 32'(busy_c), 32'h0);
        drive(2, 1'b1);
        repeat (32) @(negedge clk);
        send_bits(2, frame(9'h02A, 7, 1, 1'b0, 2, 1'b1), 11);
        repeat (4) @(negedge clk);
        check("t3_rearm_cnt", 32'(cnt_c), 32'd2);
        check("t3_rearm_po", 32'(po_c), 32'h2A);
        check("t3_rearm_fe", 32'(fe_c), 32'h0);
        check("t3_rearm_pe", 32'(pe_c), 32'h0);

        drive(0, 1'b0);
        repeat (4) @(negedge clk);
        check("t4_busy_glitch", 32'(busy_a), 32'h1);
        @(negedge clk);
        drive(0, 1'b1);
        repeat (40) @(negedge clk);
        check("t4_cnt", 32'(cnt_a), 32'd1);
        check("t4_busy", 32'(busy_a), 32'h0);
        check("t4_po", 32'(po_a), 32'hA5);
        check("t4_fe", 32'(fe_a), 32'h0);

        send_bits(0, frame(9'h03C, 8, 0, 1'b0, 1, 1'b1), 10);
        check("t5_cnt1", 32'(cnt_a), 32'd2);
        check("t5_po1", 32'(po_a), 32'h3C);
        send_bits(0, frame(9'h0C3, 8, 0, 1'b0, 1, 1'b1), 10);
        repeat (4) @(negedge clk);
        check("t5_cnt2", 32'(cnt_a), 32'd3);
        check("t5_po2", 32'(po_a), 32'hC3);

        send_bits(0, frame(9'h081, 8, 0, 1'b0, 1, 1'b1), 5);
        drive(0, 1'b0);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("t6_rst_po", 32'(po_a), 32'h0);
        check("t6_rst_dv", 32'(dv_a), 32'h0);
        check("t6_rst_busy", 32'(busy_a), 32'h0);
        check("t6_rst_fe", 32'(fe_a), 32'h0);
        drive(0, 1'b1);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (32) @(negedge clk);
        check("t6_abort_cnt", 32'(cnt_a), 32'd3);
        send_bits(0, frame(9'h081, 8, 0, 1'b0, 1, 1'b1), 10);
        repeat (4) @(negedge clk);
        check("t6_cnt", 32'(cnt_a), 32'd4);
        check("t6_po", 32'(po_a), 32'h81);
        check("t6_fe", 32'(fe_a), 32'h0);

        check("dv_double", 32'(dbl), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
